// File: rtl/cache_pkg.sv
// Shared types and helpers for the direct-mapped write-back data cache
// and its DRAM request FIFO port.
package cache_pkg;
    localparam int   INDEX_W_DEF = 8;
    localparam int   LINE_ADDR_W = 24;
    localparam logic CMD_READ    = 1'b1;
    localparam logic CMD_WRITE   = 1'b0;

    typedef logic [127:0] line_t;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, WB_REQ, FILL_REQ, FILL_WAIT, RESPOND
    } state_t;

    typedef struct packed {
        logic [26:0] addr;
        line_t       data;
        logic        cmd;
    } fifo_req_t;

    typedef struct packed {
        line_t data;
    } fifo_rsp_t;

    function automatic int tag_w(int index_w);
        return LINE_ADDR_W - index_w;
    endfunction

    // Overlay the enabled bytes of a store word onto word slot 'word' of a line.
    function automatic line_t merge_line(line_t line, logic [1:0] word,
                                         logic [31:0] wdata, logic [3:0] wstrb);
        line_t r;
        r = line;
        for (int b = 0; b < 4; b++)
            if (wstrb[b]) r[32*word + 8*b +: 8] = wdata[8*b +: 8];
        return r;
    endfunction
endpackage

// File: rtl/master_fifo.sv
// DRAM request/response FIFO port: 128-bit line reads and writes.
interface master_fifo;
    import cache_pkg::*;
    fifo_req_t req;
    logic      req_en;
    logic      req_rdy;
    fifo_rsp_t rsp;
    logic      rsp_en;
    logic      rsp_rdy;

    modport master (output req, req_en, rsp_rdy, input req_rdy, rsp, rsp_en);
    modport slave  (input req, req_en, rsp_rdy, output req_rdy, rsp, rsp_en);
endinterface

// File: rtl/dcache_ram.sv
// Simple dual-port line store {dirty, tag, data}; registered read, one-cycle latency.
module dcache_ram #(
    parameter int AW = 8,
    parameter int DW = 145
) (
    input  logic          clk,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data
);
    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
    end
endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back, write-allocate data cache; one CPU request in flight,
// line fills and evictions through the master_fifo port.
module dcache import cache_pkg::*; #(
    parameter int INDEX_W = INDEX_W_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cpu_req_valid,
    output logic        cpu_req_ready,
    input  logic        cpu_req_we,
    input  logic [27:0] cpu_req_addr,
    input  logic [31:0] cpu_req_wdata,
    input  logic [3:0]  cpu_req_wstrb,
    output logic        cpu_rsp_valid,
    output logic [31:0] cpu_rsp_rdata,
    master_fifo.master  fifo
);
    localparam int TAG_W = tag_w(INDEX_W);
    localparam int ENT_W = 1 + TAG_W + 128;

    state_t              r_state, w_next;
    logic                r_ready;
    logic                r_we;
    logic [27:2]         r_addr;
    logic [31:0]         r_wdata;
    logic [3:0]          r_wstrb;
    logic [31:0]         r_rdata;
    logic [2**INDEX_W-1:0] r_valid;
    logic                r_req_en;
    logic                r_req_cmd;
    logic [26:0]         r_req_addr;
    line_t               r_req_data;

    logic [INDEX_W-1:0]  w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [1:0]          w_word;
    logic                w_accept;
    logic [ENT_W-1:0]    w_ent;
    logic                w_ram_dirty;
    logic [TAG_W-1:0]    w_ram_tag;
    line_t               w_ram_data;
    logic                w_hit;
    logic                w_victim_dirty;
    logic                w_fill;
    line_t               w_fill_line;
    logic                w_wr_en;
    logic [ENT_W-1:0]    w_wr_ent;
    logic                w_unused_addr;

    assign w_idx          = r_addr[4 +: INDEX_W];
    assign w_tag          = r_addr[27 -: TAG_W];
    assign w_word         = r_addr[3:2];
    assign w_accept       = (r_state == IDLE) && cpu_req_valid && r_ready;
    assign w_ram_dirty    = w_ent[ENT_W-1];
    assign w_ram_tag      = w_ent[128 +: TAG_W];
    assign w_ram_data     = w_ent[127:0];
    assign w_hit          = r_valid[w_idx] && (w_ram_tag == w_tag);
    assign w_victim_dirty = r_valid[w_idx] && w_ram_dirty;
    assign w_fill         = (r_state == FILL_WAIT) && fifo.rsp_en;
    assign w_fill_line    = r_we ? merge_line(fifo.rsp.data, w_word, r_wdata, r_wstrb)
                                 : fifo.rsp.data;
    assign w_wr_en        = w_fill || ((r_state == LOOKUP) && w_hit && r_we);
    assign w_wr_ent       = w_fill ? {r_we, w_tag, w_fill_line}
                                   : {1'b1, w_tag, merge_line(w_ram_data, w_word, r_wdata, r_wstrb)};
    assign w_unused_addr  = &{1'b0, cpu_req_addr[1:0]};

    assign cpu_req_ready  = r_ready;
    assign cpu_rsp_valid  = (r_state == RESPOND);
    assign cpu_rsp_rdata  = r_rdata;
    assign fifo.req       = {r_req_addr, r_req_data, r_req_cmd};
    assign fifo.req_en    = r_req_en;
    assign fifo.rsp_rdy   = (r_state == FILL_WAIT);

    dcache_ram #(.AW(INDEX_W), .DW(ENT_W)) u_ram (
        .clk       (clk),
        .i_rd_en   (w_accept),
        .i_rd_addr (cpu_req_addr[4 +: INDEX_W]),
        .o_rd_data (w_ent),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_idx),
        .i_wr_data (w_wr_ent)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (w_accept) w_next = LOOKUP;
            LOOKUP:    w_next = w_hit ? RESPOND : (w_victim_dirty ? WB_REQ : FILL_REQ);
            WB_REQ:    if (fifo.req_rdy) w_next = FILL_REQ;
            FILL_REQ:  if (fifo.req_rdy) w_next = FILL_WAIT;
            FILL_WAIT: if (fifo.rsp_en) w_next = RESPOND;
            RESPOND:   w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // DRAM request fields are registered so they hold steady across req_rdy stalls.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_ready    <= 1'b0;
            r_valid    <= '0;
            r_rdata    <= '0;
            r_req_en   <= 1'b0;
            r_req_cmd  <= CMD_WRITE;
            r_req_addr <= '0;
            r_req_data <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == IDLE);
            if (w_accept) begin
                r_we    <= cpu_req_we;
                r_addr  <= cpu_req_addr[27:2];
                r_wdata <= cpu_req_wdata;
                r_wstrb <= cpu_req_wstrb;
            end
            case (r_state)
                LOOKUP: begin
                    if (w_hit) begin
                        r_rdata <= r_we ? 32'd0 : w_ram_data[32*w_word +: 32];
                    end else if (w_victim_dirty) begin
                        r_req_en   <= 1'b1;
                        r_req_cmd  <= CMD_WRITE;
                        r_req_addr <= {w_ram_tag, w_idx, 3'b000};
                        r_req_data <= w_ram_data;
                    end else begin
                        r_req_en   <= 1'b1;
                        r_req_cmd  <= CMD_READ;
                        r_req_addr <= {r_addr[27:4], 3'b000};
                        r_req_data <= '0;
                    end
                end
                WB_REQ: if (fifo.req_rdy) begin
                    r_req_cmd  <= CMD_READ;
                    r_req_addr <= {r_addr[27:4], 3'b000};
                    r_req_data <= '0;
                end
                FILL_REQ: if (fifo.req_rdy) r_req_en <= 1'b0;
                FILL_WAIT: if (fifo.rsp_en) begin
                    r_valid[w_idx] <= 1'b1;
                    r_rdata        <= r_we ? 32'd0 : fifo.rsp.data[32*w_word +: 32];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: flat reference memory feeds a response scoreboard,
// a behavioral DRAM responder checks writebacks and request stability.
module tb_dcache;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cpu_req_valid = 1'b0;
    logic        cpu_req_ready;
    logic        cpu_req_we = 1'b0;
    logic [27:0] cpu_req_addr = '0;
    logic [31:0] cpu_req_wdata = '0;
    logic [3:0]  cpu_req_wstrb = '0;
    logic        cpu_rsp_valid;
    logic [31:0] cpu_rsp_rdata;

    master_fifo fifo_if();

    dcache #(.INDEX_W(8)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_ready (cpu_req_ready),
        .cpu_req_we    (cpu_req_we),
        .cpu_req_addr  (cpu_req_addr),
        .cpu_req_wdata (cpu_req_wdata),
        .cpu_req_wstrb (cpu_req_wstrb),
        .cpu_rsp_valid (cpu_rsp_valid),
        .cpu_rsp_rdata (cpu_rsp_rdata),
        .fifo          (fifo_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference memory, DRAM contents and a tag-level cache model
    line_t dram_mem [int];
    line_t ref_mem  [int];
    bit    mdl_valid [256];
    bit    mdl_dirty [256];
    int    mdl_tag   [256];
    logic [31:0] sb [$];

    function automatic line_t dram_init(int la);
        logic [23:0] l;
        if (la == 4) return 128'h44444444_33333333_22222222_11111111;
        l = la[23:0];
        return {8'hA3, l, 8'hA2, l, 8'hA1, l, 8'hA0, l};
    endfunction

    function automatic line_t dram_get(int la);
        if (dram_mem.exists(la)) return dram_mem[la];
        return dram_init(la);
    endfunction

    function automatic line_t ref_get(int la);
        if (ref_mem.exists(la)) return ref_mem[la];
        return dram_init(la);
    endfunction

    function automatic line_t tb_merge(line_t l, int w, logic [31:0] d, logic [3:0] s);
        line_t r;
        r = l;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[32*w + 8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // DRAM responder
    bit          stall_en = 0;
    bit          hold_rsp = 0;
    int          pend_cnt = -1;
    line_t       pend_data;
    int          n_rd = 0, n_wr = 0, n_ev = 0;
    int          last_rd_ev = 0, last_wr_ev = 0;
    logic [26:0] last_rd_addr = '0, last_wr_addr = '0;
    line_t       last_wr_data = '0;
    bit          prev_stall = 0;
    fifo_req_t   saved_req;

    initial begin : responder
        int la;
        fifo_if.req_rdy  = 1'b0;
        fifo_if.rsp_en   = 1'b0;
        fifo_if.rsp.data = '0;
        forever begin
            @(negedge clk);
            fifo_if.rsp_en = 1'b0;
            if (pend_cnt > 0) pend_cnt--;
            else if (pend_cnt == 0 && !hold_rsp) begin
                fifo_if.rsp_en   = 1'b1;
                fifo_if.rsp.data = pend_data;
                pend_cnt = -1;
            end
            if (prev_stall && rstn) begin
                n_tests++;
                if (fifo_if.req_en !== 1'b1 || fifo_if.req !== saved_req) begin
                    n_fail++;
                    $display("FAIL req_stable: en=%b req=%h required en=1 req=%h",
                             fifo_if.req_en, fifo_if.req, saved_req);
                end
            end
            fifo_if.req_rdy = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
            prev_stall = (fifo_if.req_en === 1'b1) && !fifo_if.req_rdy;
            saved_req  = fifo_if.req;
            if (fifo_if.req_en === 1'b1 && fifo_if.req_rdy && rstn) begin
                la = int'(fifo_if.req.addr[26:3]);
                n_ev++;
                if (fifo_if.req.cmd) begin
                    n_rd++;
                    last_rd_ev   = n_ev;
                    last_rd_addr = fifo_if.req.addr;
                    pend_data    = dram_get(la);
                    pend_cnt     = stall_en ? int'($urandom_range(0, 9)) : 0;
                end else begin
                    n_wr++;
                    last_wr_ev   = n_ev;
                    last_wr_addr = fifo_if.req.addr;
                    last_wr_data = fifo_if.req.data;
                    n_tests++;
                    if (fifo_if.req.data !== ref_get(la)) begin
                        n_fail++;
                        $display("FAIL wb_data: line %h data=%h required %h",
                                 la, fifo_if.req.data, ref_get(la));
                    end
                    dram_mem[la] = fifo_if.req.data;
                end
            end
        end
    end

    // Response monitor / scoreboard
    int last_rsp_cyc = 0;
    initial begin : monitor
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            if (cpu_rsp_valid === 1'b1) begin
                last_rsp_cyc = cyc;
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected: rdata=%h required no response", cpu_rsp_rdata);
                end else begin
                    exp = sb.pop_front();
                    if (cpu_rsp_rdata !== exp) begin
                        n_fail++;
                        $display("FAIL rsp_rdata: got %h required %h", cpu_rsp_rdata, exp);
                    end
                end
            end
        end
    end

    task automatic do_req(input bit we, input logic [27:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input bit wait_rsp);
        int la, idx, tag, w, r0, w0, acc_cyc, i;
        bit hit, wb;
        line_t l;
        la  = int'(addr[27:4]);
        idx = int'(addr[11:4]);
        tag = int'(addr[27:12]);
        w   = int'(addr[3:2]);
        hit = mdl_valid[idx] && mdl_tag[idx] == tag;
        wb  = !hit && mdl_valid[idx] && mdl_dirty[idx];
        l = ref_get(la);
        if (we) begin
            ref_mem[la] = tb_merge(l, w, wd, ws);
            sb.push_back(32'd0);
        end else begin
            sb.push_back(l[32*w +: 32]);
        end
        mdl_dirty[idx] = hit ? (mdl_dirty[idx] | we) : we;
        mdl_valid[idx] = 1'b1;
        mdl_tag[idx]   = tag;
        r0 = n_rd;
        w0 = n_wr;
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_we    = we;
        cpu_req_addr  = addr;
        cpu_req_wdata = wd;
        cpu_req_wstrb = ws;
        for (i = 0; i < 50 && cpu_req_ready !== 1'b1; i++) @(negedge clk);
        n_tests++;
        if (cpu_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_timeout: addr %h ready=%b required 1", addr, cpu_req_ready);
            cpu_req_valid = 1'b0;
            void'(sb.pop_back());
            return;
        end
        acc_cyc = cyc;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        if (!wait_rsp) return;
        for (i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL rsp_timeout: addr %h pending=%0d required 0", addr, sb.size());
            sb.delete();
        end
        n_tests++;
        if (n_rd - r0 != (hit ? 0 : 1) || n_wr - w0 != (wb ? 1 : 0)) begin
            n_fail++;
            $display("FAIL dram_count: addr %h reads=%0d writes=%0d required %0d/%0d",
                     addr, n_rd - r0, n_wr - w0, hit ? 0 : 1, wb ? 1 : 0);
        end
        if (hit) begin
            n_tests++;
            if (last_rsp_cyc - acc_cyc != 2) begin
                n_fail++;
                $display("FAIL hit_latency: addr %h got %0d cycles required 2",
                         addr, last_rsp_cyc - acc_cyc);
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata, fifo_if.req_en, fifo_if.rsp_rdy} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_cpu_side: rdy=%b vld=%b rdata=%h req_en=%b rsp_rdy=%b required all 0",
                     cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata, fifo_if.req_en, fifo_if.rsp_rdy);
        end
        n_tests++;
        if (fifo_if.req.addr !== 27'd0 || fifo_if.req.data !== 128'd0 || fifo_if.req.cmd !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_req_fields: req=%h required 0", fifo_if.req);
        end
        rstn = 1'b1;
        @(negedge clk);
        n_tests++;
        if (cpu_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b required 1", cpu_req_ready);
        end
    endtask

    task automatic test_cold_load();
        do_req(1'b0, 28'h0000040, 32'd0, 4'd0, 1'b1);
        n_tests++;
        if (last_rd_addr !== 27'h0000020) begin
            n_fail++;
            $display("FAIL cold_rd_addr: got %h required 0000020", last_rd_addr);
        end
    endtask

    task automatic test_hit();
        do_req(1'b0, 28'h0000044, 32'd0, 4'd0, 1'b1);
    endtask

    task automatic test_store_hit();
        do_req(1'b1, 28'h0000040, 32'hAABBCCDD, 4'b0011, 1'b1);
        do_req(1'b0, 28'h0000040, 32'd0, 4'd0, 1'b1);
    endtask

    task automatic test_dirty_conflict();
        do_req(1'b0, 28'h0001040, 32'd0, 4'd0, 1'b1);
        n_tests++;
        if (last_wr_addr !== 27'h0000020 || last_wr_data[31:0] !== 32'h1111CCDD) begin
            n_fail++;
            $display("FAIL wb_victim: addr=%h word0=%h required 0000020/1111ccdd",
                     last_wr_addr, last_wr_data[31:0]);
        end
        n_tests++;
        if (last_rd_addr !== 27'h0000820 || last_wr_ev >= last_rd_ev) begin
            n_fail++;
            $display("FAIL fill_after_wb: rd_addr=%h wr_ev=%0d rd_ev=%0d required 0000820 with write first",
                     last_rd_addr, last_wr_ev, last_rd_ev);
        end
    endtask

    task automatic test_store_miss();
        do_req(1'b1, 28'h0003058, 32'h5566_7788, 4'b1100, 1'b1);
        do_req(1'b0, 28'h0003058, 32'd0, 4'd0, 1'b1);
        do_req(1'b0, 28'h0003054, 32'd0, 4'd0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            do_req(i[0], 28'h0003050 | 28'(i << 2), 32'h0F0F_0000 | 32'(i), 4'b1111, 1'b1);
        for (int i = 0; i < 4; i++)
            do_req(1'b0, 28'h0003050 | 28'(i << 2), 32'd0, 4'd0, 1'b1);
    endtask

    task automatic test_stall();
        logic [27:0] a;
        stall_en = 1;
        for (int i = 0; i < 40; i++) begin
            a = {14'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 4'($urandom_range(0, 3) << 2), 2'b00};
            do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(1, 15)), 1'b1);
        end
        stall_en = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_fill_wait();
        int i;
        hold_rsp = 1;
        do_req(1'b0, 28'h0000044, 32'd0, 4'd0, 1'b0);
        for (i = 0; i < 100 && fifo_if.rsp_rdy !== 1'b1; i++) @(negedge clk);
        n_tests++;
        if (fifo_if.rsp_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reach_fill_wait: rsp_rdy=%b required 1", fifo_if.rsp_rdy);
        end
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        n_tests++;
        if ({cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata, fifo_if.req_en, fifo_if.rsp_rdy} !== 35'd0) begin
            n_fail++;
            $display("FAIL midop_reset_cpu_side: rdy=%b vld=%b rdata=%h req_en=%b rsp_rdy=%b required all 0",
                     cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata, fifo_if.req_en, fifo_if.rsp_rdy);
        end
        n_tests++;
        if (fifo_if.req.addr !== 27'd0 || fifo_if.req.data !== 128'd0 || fifo_if.req.cmd !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_reset_req_fields: req=%h required 0", fifo_if.req);
        end
        // Dirty lines still in the cache are lost; DRAM is now the truth.
        sb.delete();
        ref_mem = dram_mem;
        for (int k = 0; k < 256; k++) mdl_valid[k] = 1'b0;
        hold_rsp = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_tests++;
            if (fifo_if.rsp_rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL stray_rsp_rdy: got %b required 0", fifo_if.rsp_rdy);
            end
        end
        do_req(1'b0, 28'h0000044, 32'd0, 4'd0, 1'b1);
        n_tests++;
        if (last_rd_addr !== 27'h0000020) begin
            n_fail++;
            $display("FAIL reload_rd_addr: got %h required 0000020", last_rd_addr);
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        for (int k = 0; k < 256; k++) begin
            mdl_valid[k] = 1'b0;
            mdl_dirty[k] = 1'b0;
            mdl_tag[k]   = 0;
        end
        test_reset();
        test_cold_load();
        test_hit();
        test_store_hit();
        test_dirty_conflict();
        test_store_miss();
        test_back_to_back();
        test_stall();
        test_reset_fill_wait();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-back, write-allocate data cache that sits between the core's load/store unit and the DRAM request FIFO. It is the initiator side of the `master_fifo` protocol: it issues 128-bit line reads (fills) and writes (evictions) and consumes read responses. One CPU request is in flight at a time. Hits complete without DRAM traffic.

## Interface
- `INDEX_W`, default 8: line-index width. 2^INDEX_W lines of 16 B each (4 KiB at default).
- `clk`  in  1  clock; all logic is on the rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `cpu_req_valid`  in  1  CPU request present.
- `cpu_req_ready`  out  1  request accepted when valid && ready.
- `cpu_req_we`  in  1  1 = store, 0 = load.
- `cpu_req_addr`  in  28  byte address; bits [1:0] are ignored.
- `cpu_req_wdata`  in  32  store data.
- `cpu_req_wstrb`  in  4  store byte enables.
- `cpu_rsp_valid`  out  1  one-cycle completion pulse, for loads and stores.
- `cpu_rsp_rdata`  out  32  load data, valid with `cpu_rsp_valid`; 0 for stores.
- `fifo`  master_fifo.master  outputs `req.addr`[26:0], `req.data`[127:0], `req.cmd` (1 = read, 0 = write), `req_en`, `rsp_rdy`; inputs `req_rdy`, `rsp.data`[127:0], `rsp_en`.

## Operation
- Address split: word = addr[3:2], index = addr[4+INDEX_W-1:4], tag = addr[27:4+INDEX_W]. Line address L = addr[27:4] (24 b). DRAM `req.addr` = {L, 3'b000}.
- Word w of a line is data[32*w +: 32]. Store merge is per byte under `wstrb`.
- Per-line state: valid (flop array, cleared by reset), dirty, tag, and 128-bit data.
- States:
  - IDLE: `cpu_req_ready`=1. On accept, latch the request, issue the array read, and go to LOOKUP.
  - LOOKUP: compare the tag.
    - Hit: loads capture the word. Stores merge into the line, write the array, and set dirty. Go to RESPOND.
    - Miss with valid and dirty: go to WB_REQ.
    - Otherwise: go to FILL_REQ.
  - WB_REQ: `req_en`=1, cmd=0, addr = {victim tag, index, 3'b000}, data = victim line. On `req_en && req_rdy`, go to FILL_REQ. Writes produce no response.
  - FILL_REQ: `req_en`=1, cmd=1, addr = {L, 3'b000}. On handshake, go to FILL_WAIT.
  - FILL_WAIT: `rsp_rdy`=1. On `rsp_en`, capture `rsp.data`, apply store merge if the request is a store, write the line, set valid, set dirty = we, select the word, and go to RESPOND.
  - RESPOND: `cpu_rsp_valid`=1 for one cycle, then go to IDLE.
- `rsp_en` outside FILL_WAIT is ignored.
- Request fields are held stable while `req_en`=1 and `req_rdy`=0. `req_en` never drops before the handshake.
- The CPU side does not retry. A new request is accepted only in IDLE.

## Timing
- Reset values:
  - `cpu_req_ready`=0, `cpu_rsp_valid`=0, `cpu_rsp_rdata`=0.
  - `req_en`=0, `rsp_rdy`=0, `req.addr`=0, `req.data`=0, `req.cmd`=0.
  - State = IDLE; all valid bits = 0.
- Hit latency: accept in cycle t, LOOKUP in t+1, `cpu_rsp_valid` in t+2. The next accept is possible in t+3.
- Miss latency: 2 + DRAM handshake wait + response wait + 1. Dirty misses add the write handshake.
- `rsp_en` is a single-cycle pulse. `rsp.data` must be captured in that same cycle.
- Simultaneous `req_rdy` and state entry: the handshake can complete in the first cycle `req_en` is high.
- Reset mid-operation (any state) returns to the reset values the next cycle. Any outstanding DRAM read is abandoned, and its late `rsp_en` is ignored under the IDLE rule.
- A store to the line being filled is merged in the same cycle as the fill write. No read-modify-write hazard exists.

## Structure
- `cache_pkg`:
  - `line_t` (logic[127:0])
  - `INDEX_W` default, TAG_W derivation
  - state enum {IDLE, LOOKUP, WB_REQ, FILL_REQ, FILL_WAIT, RESPOND}
  - byte-merge function
  - DRAM cmd constants CMD_READ=1, CMD_WRITE=0
- Sub-module `dcache_ram`: a simple-dual-port block RAM holding {dirty, tag, data} per index, with 1-cycle read latency. Valid bits stay in `dcache` as flops so reset can clear them.

## Test plan
- Cold load: after reset, load 0x0000040 -> exactly one DRAM read with addr 27'h0000020. Return data 128'h44444444_33333333_22222222_11111111 -> `cpu_rsp_rdata`=0x11111111.
- Hit: then load 0x0000044 -> no `req_en`; `cpu_rsp_valid` 2 cycles after accept; rdata=0x22222222.
- Store hit: store 0x0000040, wdata 0xAABBCCDD, wstrb 4'b0011 -> no DRAM traffic. A following load of 0x0000040 returns 0x1111CCDD.
- Dirty conflict: load 0x0001040 (same index, tag 1) -> DRAM write first, addr 27'h0000020, data word0 = 0x1111CCDD, then DRAM read addr 27'h0000820. Response word0 returned to the CPU.
- Responder stalls: random `req_rdy`-low and response delays of 1–10 cycles -> `req_en`/addr/data/cmd stay stable until the handshake; each `rsp_en` pulse is captured; one DRAM read per miss.
- Reset in FILL_WAIT: assert `rstn`=0 for 1 cycle -> all outputs 0 next cycle. A stray `rsp_en` afterwards is ignored. A reload of 0x0000044 misses and issues a DRAM read.
